// File: rtl/secuenciador_barrido.sv
// Timed address sequencer for a 4-to-16 decoder: sweeps a latched address window
// up or down, holding each address Divisor+1 cycles, in single-shot or wrap-around mode.
module secuenciador_barrido #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Arranque,
  input  logic                 Parada,
  input  logic                 Modo,
  input  logic                 Sentido,
  input  logic [3:0]           Inicio,
  input  logic [3:0]           Fin,
  input  logic [DIV_WIDTH-1:0] Divisor,
  output logic [3:0]           Direccion,
  output logic                 Habilitar,
  output logic                 FinBarrido
);

  typedef enum logic {REPOSO = 1'b0, ACTIVO = 1'b1} estado_t;

  estado_t                estado_reg, estado_next;
  logic [3:0]             direccion_reg, direccion_next;
  logic                   fin_barrido_reg, fin_barrido_next;
  logic [DIV_WIDTH-1:0]   presc_reg, presc_next;
  logic                   modo_reg, modo_next;
  logic                   sentido_reg, sentido_next;
  logic [3:0]             inicio_reg, inicio_next;
  logic [3:0]             fin_reg, fin_next;
  logic [DIV_WIDTH-1:0]   divisor_reg, divisor_next;
  logic                   tick;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      estado_reg      <= REPOSO;
      direccion_reg   <= '0;
      fin_barrido_reg <= 1'b0;
      presc_reg       <= '0;
      modo_reg        <= 1'b0;
      sentido_reg     <= 1'b0;
      inicio_reg      <= '0;
      fin_reg         <= '0;
      divisor_reg     <= '0;
    end else begin
      estado_reg      <= estado_next;
      direccion_reg   <= direccion_next;
      fin_barrido_reg <= fin_barrido_next;
      presc_reg       <= presc_next;
      modo_reg        <= modo_next;
      sentido_reg     <= sentido_next;
      inicio_reg      <= inicio_next;
      fin_reg         <= fin_next;
      divisor_reg     <= divisor_next;
    end
  end

  assign tick = (presc_reg == divisor_reg);

  always_comb begin
    estado_next      = estado_reg;
    direccion_next   = direccion_reg;
    fin_barrido_next = 1'b0;
    presc_next       = presc_reg;
    modo_next        = modo_reg;
    sentido_next     = sentido_reg;
    inicio_next      = inicio_reg;
    fin_next         = fin_reg;
    divisor_next     = divisor_reg;
    case (estado_reg)
      REPOSO: begin
        // Stop wins over start so a held Parada keeps the block parked.
        if (Arranque && !Parada) begin
          modo_next      = Modo;
          sentido_next   = Sentido;
          inicio_next    = Inicio;
          fin_next       = Fin;
          divisor_next   = Divisor;
          direccion_next = Inicio;
          presc_next     = '0;
          estado_next    = ACTIVO;
        end
      end
      ACTIVO: begin
        if (Parada) begin
          estado_next = REPOSO;
          presc_next  = '0;
        end else if (tick) begin
          presc_next = '0;
          if (direccion_reg == fin_reg) begin
            fin_barrido_next = 1'b1;
            if (modo_reg) direccion_next = inicio_reg;
            else          estado_next    = REPOSO;
          end else if (sentido_reg) begin
            direccion_next = direccion_reg - 4'd1;
          end else begin
            direccion_next = direccion_reg + 4'd1;
          end
        end else begin
          presc_next = presc_reg + 1'b1;
        end
      end
      default: estado_next = REPOSO;
    endcase
  end

  assign Direccion  = direccion_reg;
  assign Habilitar  = (estado_reg == ACTIVO);
  assign FinBarrido = fin_barrido_reg;

endmodule

// File: tb/tb_secuenciador_barrido.sv
// Scoreboard bench for secuenciador_barrido: a window/dwell arithmetic model predicts each
// cycle's outputs into a queue; a monitor pops and compares one entry after every clock edge.
module tb_secuenciador_barrido;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Arranque = 1'b0, Parada = 1'b0, Modo = 1'b0, Sentido = 1'b0;
  logic [3:0] Inicio = '0, Fin = '0;
  logic [7:0] Divisor = '0;
  logic [3:0] Direccion;
  logic       Habilitar, FinBarrido;

  secuenciador_barrido #(.DIV_WIDTH(8)) dut (
    .Clock(Clock), .Reset(Reset), .Arranque(Arranque), .Parada(Parada),
    .Modo(Modo), .Sentido(Sentido), .Inicio(Inicio), .Fin(Fin),
    .Divisor(Divisor), .Direccion(Direccion), .Habilitar(Habilitar),
    .FinBarrido(FinBarrido)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [3:0] dir;
    logic       hab;
    logic       fin;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: sweep described by elapsed cycles m_t within a window of m_n addresses.
  bit   m_act = 0;
  int   m_t = 0, m_n = 1, m_div = 0, m_ini = 0, m_fin = 0;
  bit   m_modo = 0, m_sen = 0;
  int   m_dir = 0;
  bit   m_finp = 0;

  function automatic int addr_at(int t);
    int idx;
    idx = t / (m_div + 1);
    return m_sen ? ((m_ini - idx + 32) % 16) : ((m_ini + idx) % 16);
  endfunction

  task automatic model_update();
    if (Reset) begin
      m_act = 0; m_t = 0; m_dir = 0; m_finp = 0;
      m_ini = 0; m_fin = 0; m_div = 0; m_modo = 0; m_sen = 0; m_n = 1;
    end else if (!m_act) begin
      m_finp = 0;
      if (Arranque && !Parada) begin
        m_ini = int'(Inicio); m_fin = int'(Fin); m_div = int'(Divisor);
        m_modo = Modo; m_sen = Sentido;
        m_n = m_sen ? ((m_ini - m_fin + 16) % 16) + 1 : ((m_fin - m_ini + 16) % 16) + 1;
        m_t = 0; m_act = 1; m_dir = m_ini;
      end
    end else if (Parada) begin
      m_act = 0; m_finp = 0;
    end else begin
      m_finp = 0;
      m_t++;
      if (m_t == m_n * (m_div + 1)) begin
        m_finp = 1;
        if (m_modo) m_t = 0;
        else        m_act = 0;
      end
      if (m_act) m_dir = addr_at(m_t);
    end
  endtask

  // Inputs are set at the falling edge; the prediction covers the next rising edge.
  task automatic step();
    exp_t e;
    model_update();
    e.dir = 4'(m_dir); e.hab = m_act; e.fin = m_finp;
    exp_q.push_back(e);
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic arrancar(bit modo, bit sen, int ini, int fin, int div);
    Modo = modo; Sentido = sen; Inicio = 4'(ini); Fin = 4'(fin); Divisor = 8'(div);
    Arranque = 1'b1; step(); Arranque = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge Clock);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (Direccion !== e.dir || Habilitar !== e.hab || FinBarrido !== e.fin) begin
          errors++;
          $display("FAIL outputs t=%0t: got dir=%0d hab=%0b fin=%0b, expected dir=%0d hab=%0b fin=%0b",
                   $time, Direccion, Habilitar, FinBarrido, e.dir, e.hab, e.fin);
        end else begin
          $display("ok t=%0t dir=%0d hab=%0b fin=%0b", $time, Direccion, Habilitar, FinBarrido);
        end
      end
    end
  end

  initial begin : stimulus
    @(negedge Clock);
    steps(2);
    Reset = 1'b0;
    steps(2);

    // Ascending single sweep 2..5 with 4-cycle dwell.
    arrancar(0, 0, 2, 5, 3);
    steps(20);
    // Wrap-around windows, 1-cycle dwell.
    arrancar(0, 0, 14, 1, 0);
    steps(6);
    arrancar(0, 1, 1, 14, 0);
    steps(6);
    // Continuous sweep 0..2 with dwell 2, then stop.
    arrancar(1, 0, 0, 2, 1);
    steps(20);
    Parada = 1'b1; step(); Parada = 1'b0;
    steps(2);
    // Stop coinciding with the tick that would leave address 3.
    arrancar(0, 0, 2, 5, 3);
    steps(7);
    Parada = 1'b1; step();
    Arranque = 1'b1; steps(3);
    Parada = 1'b0; Arranque = 1'b0;
    steps(2);
    // Config changes and Arranque pulses during a sweep are ignored.
    arrancar(0, 0, 7, 9, 2);
    Inicio = 4'd1; Fin = 4'd12; Sentido = 1'b1; Divisor = 8'd0; Modo = 1'b1;
    steps(2);
    Arranque = 1'b1; step(); Arranque = 1'b0;
    steps(8);
    // Held Arranque in single mode: one idle cycle between sweeps.
    Modo = 1'b0; Sentido = 1'b0; Inicio = 4'd3; Fin = 4'd4; Divisor = 8'd1;
    Arranque = 1'b1; steps(14); Arranque = 1'b0;
    steps(3);

    // Asynchronous reset between edges.
    arrancar(1, 0, 5, 10, 2);
    steps(5);
    #2 Reset = 1'b1;
    #1;
    checks++;
    if (Direccion !== 4'd0 || Habilitar !== 1'b0 || FinBarrido !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got dir=%0d hab=%0b fin=%0b, expected dir=0 hab=0 fin=0",
               Direccion, Habilitar, FinBarrido);
    end else begin
      $display("ok async_reset dir=0 hab=0 fin=0");
    end
    step();
    Reset = 1'b0;
    steps(4);

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      Arranque = ($urandom_range(0, 3) == 0);
      Parada   = ($urandom_range(0, 49) == 0);
      Modo     = $urandom_range(0, 1);
      Sentido  = $urandom_range(0, 1);
      Inicio   = 4'($urandom_range(0, 15));
      Fin      = 4'($urandom_range(0, 15));
      Divisor  = 8'($urandom_range(0, 4));
      step();
    end
    Arranque = 1'b0; Parada = 1'b0;
    steps(2);

    @(posedge Clock); #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/secuenciador_barrido.md
Name: secuenciador_barrido

Overview:
- Timed address sequencer driving the 4-to-16 decoder stage: produces its 4-bit select code (Direccion) and its enable (Habilitar).
- Sweeps a programmable address window, up or down, holding each address for a programmable number of clock cycles.
- Used for LED/display column scanning and one-hot strobing.
- Supports single-sweep and continuous (wrap-around) modes.

Parameters:
- DIV_WIDTH, 8, width of the per-address dwell divisor (Divisor port and internal prescaler).

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Arranque  input  1  start request. Sampled only in REPOSO.
- Parada  input  1  synchronous stop. Aborts a sweep.
- Modo  input  1  0 = single sweep, 1 = continuous.
- Sentido  input  1  0 = ascending, 1 = descending.
- Inicio  input  4  first address of window.
- Fin  input  4  last address of window.
- Divisor  input  DIV_WIDTH  dwell per address = Divisor+1 cycles.
- Direccion  output  4  select code to decoder.
- Habilitar  output  1  enable to decoder. High only while sweeping.
- FinBarrido  output  1  one-cycle pulse when the window's last address completes its dwell.

Behaviour:
- Reset (async) forces:
  - state REPOSO;
  - Direccion=0, Habilitar=0, FinBarrido=0;
  - prescaler=0;
  - all latched configuration = 0.
- All outputs are registered. There is no combinational path from inputs to outputs.
- States: REPOSO, ACTIVO. Habilitar=1 exactly when state=ACTIVO.
- REPOSO transitions:
  - Arranque=1 and Parada=0 at edge k: latch Modo, Sentido, Inicio, Fin, Divisor; Direccion<=Inicio; prescaler<=0; Habilitar<=1; state<=ACTIVO. Outputs are valid after edge k (latency 1).
  - Parada=1 has priority over Arranque in REPOSO: the block stays in REPOSO.
- ACTIVO, prescaler:
  - Counts 0..Divisor_latched.
  - tick = (prescaler==Divisor_latched). On tick, prescaler<=0.
  - Divisor=0 gives a tick every cycle (dwell of 1 cycle).
- ACTIVO, on tick with Direccion != Fin_latched:
  - Ascending: Direccion<=Direccion+1 mod 16 (15 -> 0 wraps).
  - Descending: Direccion<=Direccion-1 mod 16 (0 -> 15 wraps).
- ACTIVO, on tick with Direccion == Fin_latched:
  - FinBarrido<=1 for exactly one cycle.
  - Modo_latched=1: Direccion<=Inicio_latched; remain ACTIVO.
  - Modo_latched=0: state<=REPOSO; Habilitar<=0; Direccion holds Fin_latched.
- Window length:
  - Ascending: N = ((Fin-Inicio) mod 16)+1.
  - Descending: N = ((Inicio-Fin) mod 16)+1.
  - Inicio==Fin gives N=1.
  - A single sweep keeps Habilitar high for exactly N*(Divisor+1) cycles.
- Parada=1 in ACTIVO:
  - Takes priority over tick.
  - Next edge: state<=REPOSO, Habilitar<=0, prescaler<=0, FinBarrido stays 0. Direccion holds its current value.
- Arranque in ACTIVO is ignored.
- Changes to Modo/Sentido/Inicio/Fin/Divisor during ACTIVO have no effect until the next start.
- Arranque held high continuously in single mode restarts the sweep on the cycle after return to REPOSO. Habilitar is low for exactly one cycle between sweeps.
- Reset asserted mid-sweep returns all outputs to reset values immediately. Operation resumes only on a new Arranque after Reset deasserts.

Test Plan:
1. Reset deassert; Inicio=2, Fin=5, Sentido=0, Modo=0, Divisor=3, Arranque pulse.
   - Direccion 2,3,4,5, each held 4 cycles.
   - Habilitar high 16 cycles.
   - FinBarrido one pulse coincident with Habilitar falling.
   - Direccion stays 5.
2. Inicio=14, Fin=1, Sentido=0, Divisor=0.
   - Direccion 14,15,0,1 on consecutive cycles; N=4.
   - Repeat descending with Inicio=1, Fin=14: sequence 1,0,15,14.
3. Modo=1, Inicio=0, Fin=2, Divisor=1.
   - Sequence 0,0,1,1,2,2,0,0,...
   - FinBarrido pulses every 6 cycles.
   - Habilitar never drops.
4. Parada asserted during Direccion=3 of test 1, same cycle as a tick.
   - Next cycle: Habilitar=0, Direccion=3, no FinBarrido.
   - Arranque+Parada together in REPOSO: stays idle.
5. Start with Inicio=7, Divisor=2; change Inicio/Fin/Sentido/Divisor mid-sweep.
   - Sweep continues with latched values.
   - Arranque pulses during ACTIVO are ignored.
6. Assert Reset asynchronously mid-sweep, between clock edges.
   - Direccion=0, Habilitar=0, FinBarrido=0 immediately.
   - No activity until a new Arranque.
